// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB master: IDLE -> SETUP -> ACCESS with registered outputs.
// Optional macro APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES cycles of PREADY low.
//  state  | meaning
//  IDLE   | bus idle; deliver previous response, arbitrate pending requests
//  SETUP  | PSEL=1 PENABLE=0, acknowledge the owner
//  ACCESS | PSEL=1 PENABLE=1, wait for PREADY (or timeout)
module apb_master_arbiter #(
  parameter int ADD_WIDTH      = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int T_WIDTH        = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADD_WIDTH-1:0]  req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_ack,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADD_WIDTH-1:0]    PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << T_WIDTH) - 1) begin : g_bad_timeout_cfg
    $error("apb_master_arbiter: TIMEOUT_CYCLES out of range for T_WIDTH");
  end

  state_t                  state, state_nxt;
  logic                    owner, owner_nxt;
  logic                    last_grant, last_grant_nxt;
  logic                    gnt;
  logic [1:0]              req_ack_nxt, rsp_valid_nxt;
  logic [DATA_WIDTH-1:0]   rsp_rdata_nxt;
  logic                    rsp_err_nxt;
  logic                    psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADD_WIDTH-1:0]    paddr_nxt;
  logic [DATA_WIDTH-1:0]   pwdata_nxt;

`ifdef APB_TIMEOUT_EN
  localparam logic [T_WIDTH-1:0] T_LIMIT = T_WIDTH'(TIMEOUT_CYCLES);
  logic [T_WIDTH-1:0]      tcnt, tcnt_nxt;
`endif

  // Lone requester wins; on a tie the one not granted last time wins.
  assign gnt = (req_valid == 2'b10) | ((req_valid == 2'b11) & ~last_grant);

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    req_ack_nxt    = '0;
    rsp_valid_nxt  = '0;
    rsp_rdata_nxt  = rsp_rdata;
    rsp_err_nxt    = rsp_err;
    psel_nxt       = 1'b0;
    penable_nxt    = 1'b0;
    pwrite_nxt     = PWRITE;
    paddr_nxt      = PADDR;
    pwdata_nxt     = PWDATA;
`ifdef APB_TIMEOUT_EN
    tcnt_nxt       = tcnt;
`endif
    case (state)
      ST_IDLE: begin
        if (|req_valid) begin
          state_nxt        = ST_SETUP;
          owner_nxt        = gnt;
          last_grant_nxt   = gnt;
          req_ack_nxt[gnt] = 1'b1;
          psel_nxt         = 1'b1;
          pwrite_nxt       = req_write[gnt];
          paddr_nxt        = gnt ? req_addr[ADD_WIDTH +: ADD_WIDTH] : req_addr[0 +: ADD_WIDTH];
          pwdata_nxt       = gnt ? req_wdata[DATA_WIDTH +: DATA_WIDTH] : req_wdata[0 +: DATA_WIDTH];
        end
      end
      ST_SETUP: begin
        state_nxt   = ST_ACCESS;
        psel_nxt    = 1'b1;
        penable_nxt = 1'b1;
`ifdef APB_TIMEOUT_EN
        tcnt_nxt    = '0;
`endif
      end
      ST_ACCESS: begin
        if (PREADY) begin
          state_nxt            = ST_IDLE;
          rsp_valid_nxt[owner] = 1'b1;
          rsp_rdata_nxt        = PWRITE ? '0 : PRDATA;
          rsp_err_nxt          = PSLVERR;
        end else begin
          psel_nxt    = 1'b1;
          penable_nxt = 1'b1;
`ifdef APB_TIMEOUT_EN
          tcnt_nxt = tcnt + 1'b1;
          if (tcnt_nxt == T_LIMIT) begin
            state_nxt            = ST_IDLE;
            psel_nxt             = 1'b0;
            penable_nxt          = 1'b0;
            rsp_valid_nxt[owner] = 1'b1;
            rsp_rdata_nxt        = '0;
            rsp_err_nxt          = 1'b1;
          end
`endif
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      req_ack    <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
`ifdef APB_TIMEOUT_EN
      tcnt       <= '0;
`endif
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      req_ack    <= req_ack_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_rdata  <= rsp_rdata_nxt;
      rsp_err    <= rsp_err_nxt;
      PSEL       <= psel_nxt;
      PENABLE    <= penable_nxt;
      PWRITE     <= pwrite_nxt;
      PADDR      <= paddr_nxt;
      PWDATA     <= pwdata_nxt;
`ifdef APB_TIMEOUT_EN
      tcnt       <= tcnt_nxt;
`endif
    end
  end

endmodule
